// File: rtl/cp0_unit_if.sv
// Pipeline-side bundle for cp0_unit: MTC0/MFC0 access, commit-stage event inputs,
// interrupt lines and the flush/redirect and register-view outputs.
interface cp0_unit_if #(
   parameter int HW_INT_NUM = 6
);
   logic                  mtc0_we;
   logic [4:0]            addr;
   logic [2:0]            sel;
   logic [31:0]           wdata;
   logic [31:0]           rdata;
   logic [HW_INT_NUM-1:0] hw_int;
   logic                  commit_valid;
   logic [31:0]           commit_pc;
   logic                  commit_bd;
   logic                  exc_valid;
   logic [4:0]            exc_code;
   logic [31:0]           exc_badvaddr;
   logic                  eret;
   logic                  int_pending;
   logic                  flush;
   logic [31:0]           flush_pc;
   logic [31:0]           status_o;
   logic [31:0]           cause_o;
   logic [31:0]           epc_o;

   // The pipeline drives commit events and register accesses; CP0 answers.
   modport master (
      output mtc0_we, addr, sel, wdata, hw_int, commit_valid, commit_pc,
             commit_bd, exc_valid, exc_code, exc_badvaddr, eret,
      input  rdata, int_pending, flush, flush_pc, status_o, cause_o, epc_o
   );

   modport slave (
      input  mtc0_we, addr, sel, wdata, hw_int, commit_valid, commit_pc,
             commit_bd, exc_valid, exc_code, exc_badvaddr, eret,
      output rdata, int_pending, flush, flush_pc, status_o, cause_o, epc_o
   );
endinterface

// File: rtl/cp0_unit.sv
// MIPS coprocessor-0 at the commit stage: BadVAddr, Count, Compare, Status, Cause, EPC, PRId.
// Optional macro CP0_TIMER_INT_EN enables the Compare register and the Count/Compare timer interrupt.
module cp0_unit #(
   parameter int          HW_INT_NUM = 6,
   parameter int          COUNT_DIV  = 2,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter logic [31:0] PRID_VAL   = 32'h0000_4220
) (
   input logic        clk,
   input logic        rst,
   cp0_unit_if.slave  bus
);

   localparam int              PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_MAX  = PW'(COUNT_DIV - 1);
   localparam logic [31:0]     STATUS_WM  = 32'h0040_FF03;
   localparam logic [31:0]     STATUS_RST = 32'h0040_0000;

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;

   logic [31:0]   badvaddr_q, badvaddr_d;
   logic [31:0]   count_q, count_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [31:0]   status_q, status_d;
   logic [31:0]   cause_q, cause_d;
   logic [31:0]   epc_q, epc_d;
   logic          flush_q, flush_d;
   logic [31:0]   flush_pc_q, flush_pc_d;
`ifdef CP0_TIMER_INT_EN
   logic [31:0]   compare_q, compare_d;
`endif

   logic        int_pend;
   logic        take_int, take_exc, take_eret, do_mtc0;
   logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
   logic        cnt_tick;
   logic [31:0] count_inc;
   logic        ti_d;
   logic [5:0]  ip_hw;

   assign int_pend = status_q[0] & ~status_q[1] & (|(status_q[15:8] & cause_q[15:8]));

   // Commit arbitration: an interrupt beats an exception beats ERET beats MTC0.
   always_comb begin
      take_int   = bus.commit_valid & int_pend;
      take_exc   = bus.commit_valid & ~int_pend & bus.exc_valid;
      take_eret  = bus.commit_valid & ~int_pend & ~bus.exc_valid & bus.eret;
      do_mtc0    = bus.commit_valid & ~int_pend & ~bus.exc_valid & ~bus.eret &
                   bus.mtc0_we & (bus.sel == 3'd0);
      wr_count   = do_mtc0 & (bus.addr == REG_COUNT);
      wr_status  = do_mtc0 & (bus.addr == REG_STATUS);
      wr_cause   = do_mtc0 & (bus.addr == REG_CAUSE);
      wr_epc     = do_mtc0 & (bus.addr == REG_EPC);
`ifdef CP0_TIMER_INT_EN
      wr_compare = do_mtc0 & (bus.addr == REG_COMPARE);
`else
      wr_compare = 1'b0;
`endif
   end

   // Count advances on prescaler wrap; an MTC0 to Count restarts the prescaler.
   always_comb begin
      cnt_tick  = (presc_q == PRESC_MAX);
      count_inc = count_q + 32'd1;
      count_d   = count_q;
      presc_d   = presc_q;
      if (wr_count) begin
         count_d = bus.wdata;
         presc_d = '0;
      end else begin
         presc_d = cnt_tick ? '0 : presc_q + 1'b1;
         if (cnt_tick) count_d = count_inc;
      end
   end

   // Timer flag: a Count or Compare write in the same cycle as a match suppresses it.
   always_comb begin
`ifdef CP0_TIMER_INT_EN
      compare_d = wr_compare ? bus.wdata : compare_q;
      ti_d      = cause_q[30];
      if (wr_compare)
         ti_d = 1'b0;
      else if (cnt_tick && !wr_count && (count_inc == compare_q))
         ti_d = 1'b1;
`else
      ti_d = 1'b0;
`endif
      ip_hw = '0;
      for (int i = 0; i < HW_INT_NUM; i++) ip_hw[i] = bus.hw_int[i];
      ip_hw[5] = ip_hw[5] | ti_d;
   end

   // Architectural register next-state; EPC/BD are frozen while already at exception level.
   always_comb begin
      status_d   = status_q;
      cause_d    = cause_q;
      epc_d      = epc_q;
      badvaddr_d = badvaddr_q;
      flush_d    = 1'b0;
      flush_pc_d = flush_pc_q;

      cause_d[30]    = ti_d;
      cause_d[15:10] = ip_hw;

      if (wr_status) status_d     = (status_q & ~STATUS_WM) | (bus.wdata & STATUS_WM);
      if (wr_cause)  cause_d[9:8] = bus.wdata[9:8];
      if (wr_epc)    epc_d        = bus.wdata;

      if (take_int || take_exc) begin
         cause_d[6:2] = take_int ? 5'd0 : bus.exc_code;
         if (!status_q[1]) begin
            epc_d       = bus.commit_bd ? bus.commit_pc - 32'd4 : bus.commit_pc;
            cause_d[31] = bus.commit_bd;
         end
         status_d[1] = 1'b1;
         if (take_exc && (bus.exc_code == 5'd4 || bus.exc_code == 5'd5))
            badvaddr_d = bus.exc_badvaddr;
         flush_d    = 1'b1;
         flush_pc_d = EXC_VECTOR;
      end else if (take_eret) begin
         status_d[1] = 1'b0;
         flush_d     = 1'b1;
         flush_pc_d  = epc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         badvaddr_q <= '0;
         count_q    <= '0;
         presc_q    <= '0;
         status_q   <= STATUS_RST;
         cause_q    <= '0;
         epc_q      <= '0;
         flush_q    <= 1'b0;
         flush_pc_q <= '0;
`ifdef CP0_TIMER_INT_EN
         compare_q  <= '0;
`endif
      end else begin
         badvaddr_q <= badvaddr_d;
         count_q    <= count_d;
         presc_q    <= presc_d;
         status_q   <= status_d;
         cause_q    <= cause_d;
         epc_q      <= epc_d;
         flush_q    <= flush_d;
         flush_pc_q <= flush_pc_d;
`ifdef CP0_TIMER_INT_EN
         compare_q  <= compare_d;
`endif
      end
   end

   always_comb begin
      bus.rdata = '0;
      if (bus.sel == 3'd0) begin
         case (bus.addr)
            REG_BADVADDR: bus.rdata = badvaddr_q;
            REG_COUNT:    bus.rdata = count_q;
`ifdef CP0_TIMER_INT_EN
            REG_COMPARE:  bus.rdata = compare_q;
`endif
            REG_STATUS:   bus.rdata = status_q;
            REG_CAUSE:    bus.rdata = cause_q;
            REG_EPC:      bus.rdata = epc_q;
            REG_PRID:     bus.rdata = PRID_VAL;
            default:      bus.rdata = '0;
         endcase
      end
   end

   assign bus.int_pending = int_pend;
   assign bus.flush       = flush_q;
   assign bus.flush_pc    = flush_pc_q;
   assign bus.status_o    = status_q;
   assign bus.cause_o     = cause_q;
   assign bus.epc_o       = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit; expectations adapt to CP0_TIMER_INT_EN.
module tb_cp0_unit;

`ifdef CP0_TIMER_INT_EN
   localparam logic TIMER_ON = 1'b1;
`else
   localparam logic TIMER_ON = 1'b0;
`endif
   localparam logic [31:0] TIMER_BITS = TIMER_ON ? 32'h4000_8000 : 32'h0000_0000;
   localparam logic [31:0] VEC        = 32'hBFC0_0380;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   cp0_unit_if #(.HW_INT_NUM(6)) bus ();

   cp0_unit #(
      .HW_INT_NUM(6),
      .COUNT_DIV (2),
      .EXC_VECTOR(32'hBFC0_0380),
      .PRID_VAL  (32'h0000_4220)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1ns after the rising edge and outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic readReg(input string tag, input logic [4:0] a, input logic [31:0] expected);
      bus.addr = a;
      bus.sel  = 3'd0;
      #1;
      checkOutput(tag, bus.rdata, expected);
   endtask

   task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d);
      bus.commit_valid = 1'b1;
      bus.mtc0_we      = 1'b1;
      bus.addr         = a;
      bus.wdata        = d;
      tick();
      bus.commit_valid = 1'b0;
      bus.mtc0_we      = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.mtc0_we = 1'b0;      bus.addr = '0;          bus.sel = '0;
      bus.wdata = '0;          bus.hw_int = '0;        bus.commit_valid = 1'b0;
      bus.commit_pc = '0;      bus.commit_bd = 1'b0;   bus.exc_valid = 1'b0;
      bus.exc_code = '0;       bus.exc_badvaddr = '0;  bus.eret = 1'b0;
      repeat (2) tick();
      rst = 1'b0;

      // Reset state of every register and of the redirect outputs
      checkOutput("rst_flush", {31'd0, bus.flush}, 32'd0);
      checkOutput("rst_flush_pc", bus.flush_pc, 32'd0);
      readReg("rst_badvaddr", 5'd8, 32'd0);
      readReg("rst_count", 5'd9, 32'd0);
      readReg("rst_compare", 5'd11, 32'd0);
      readReg("rst_status", 5'd12, 32'h0040_0000);
      readReg("rst_cause", 5'd13, 32'd0);
      readReg("rst_epc", 5'd14, 32'd0);
      readReg("rst_prid", 5'd15, 32'h0000_4220);
      readReg("rst_unimpl", 5'd0, 32'd0);
      bus.addr = 5'd15;
      bus.sel  = 3'd1;
      #1;
      checkOutput("sel_nonzero", bus.rdata, 32'd0);
      bus.sel = 3'd0;
      tick();

      // Timer: Count=5, Compare=8, Status IM7|IE, then count up to the match
      applyStimulus(5'd9, 32'd5);
      readReg("count_load", 5'd9, 32'd5);
      applyStimulus(5'd11, 32'd8);
      applyStimulus(5'd12, 32'h0000_8001);
      checkOutput("status_wr", bus.status_o, 32'h0000_8001);
      repeat (3) tick();
      checkOutput("ti_before", bus.cause_o, 32'd0);
      tick();
      checkOutput("ti_set", bus.cause_o, TIMER_BITS);
      checkOutput("ti_intpend", {31'd0, bus.int_pending}, {31'd0, TIMER_ON});
      readReg("count_at_match", 5'd9, 32'd8);

      // hw_int[5] drives IP7 regardless of the timer build option
      bus.hw_int = 6'b100000;
      tick();
      checkOutput("hw5_cause", bus.cause_o, 32'h0000_8000 | TIMER_BITS);
      checkOutput("hw5_intpend", {31'd0, bus.int_pending}, 32'd1);

      bus.commit_valid = 1'b1;
      bus.commit_pc    = 32'h100;
      tick();
      bus.commit_valid = 1'b0;
      bus.hw_int       = 6'b000000;
      checkOutput("int_flush", {31'd0, bus.flush}, 32'd1);
      checkOutput("int_flush_pc", bus.flush_pc, VEC);
      checkOutput("int_epc", bus.epc_o, 32'h100);
      checkOutput("int_status", bus.status_o, 32'h0000_8003);
      checkOutput("int_cause", bus.cause_o, 32'h0000_8000 | TIMER_BITS);
      checkOutput("int_exl_mask", {31'd0, bus.int_pending}, 32'd0);
      tick();
      checkOutput("flush_pulse", {31'd0, bus.flush}, 32'd0);
      checkOutput("flush_pc_hold", bus.flush_pc, VEC);

      // Clear EXL/IE, then AdEL in a delay slot
      applyStimulus(5'd12, 32'd0);
      checkOutput("status_clear", bus.status_o, 32'd0);
      bus.commit_valid = 1'b1;   bus.exc_valid = 1'b1;   bus.exc_code = 5'd4;
      bus.commit_bd = 1'b1;      bus.commit_pc = 32'h204; bus.exc_badvaddr = 32'h1001;
      tick();
      checkOutput("adel_epc", bus.epc_o, 32'h200);
      checkOutput("adel_cause", bus.cause_o, 32'h8000_0010 | TIMER_BITS);
      checkOutput("adel_status", bus.status_o, 32'h0000_0002);
      checkOutput("adel_flush_pc", bus.flush_pc, VEC);
      readReg("adel_badvaddr", 5'd8, 32'h1001);

      // Nested exception at EXL=1 keeps EPC/BD; Ov does not touch BadVAddr
      bus.exc_code = 5'd12;   bus.commit_bd = 1'b0;
      bus.commit_pc = 32'h300; bus.exc_badvaddr = 32'h2222;
      tick();
      checkOutput("nest_epc", bus.epc_o, 32'h200);
      checkOutput("nest_cause", bus.cause_o, 32'h8000_0030 | TIMER_BITS);
      checkOutput("nest_flush", {31'd0, bus.flush}, 32'd1);
      readReg("nest_badvaddr", 5'd8, 32'h1001);

      // ERET redirects to EPC and drops EXL
      bus.exc_valid = 1'b0;
      bus.eret      = 1'b1;
      tick();
      bus.eret         = 1'b0;
      bus.commit_valid = 1'b0;
      checkOutput("eret_flush", {31'd0, bus.flush}, 32'd1);
      checkOutput("eret_flush_pc", bus.flush_pc, 32'h200);
      checkOutput("eret_status", bus.status_o, 32'd0);
      tick();
      checkOutput("eret_pulse", {31'd0, bus.flush}, 32'd0);

      // Exception and MTC0 Status in the same cycle: the write is dropped
      bus.commit_valid = 1'b1;  bus.exc_valid = 1'b1;  bus.exc_code = 5'd10;
      bus.commit_pc = 32'h400;  bus.commit_bd = 1'b0;
      bus.mtc0_we = 1'b1;       bus.addr = 5'd12;      bus.wdata = 32'h0040_FF01;
      tick();
      bus.commit_valid = 1'b0;  bus.exc_valid = 1'b0;  bus.mtc0_we = 1'b0;
      checkOutput("supp_status", bus.status_o, 32'h0000_0002);
      checkOutput("supp_epc", bus.epc_o, 32'h400);
      checkOutput("supp_cause", bus.cause_o, 32'h0000_0028 | TIMER_BITS);

      // Software interrupt path; a Compare write clears TI first
      applyStimulus(5'd12, 32'h0000_0101);
      checkOutput("sw_status", bus.status_o, 32'h0000_0101);
      checkOutput("sw_nopend", {31'd0, bus.int_pending}, 32'd0);
      applyStimulus(5'd11, 32'h1234);
      checkOutput("cmp_clr_ti", bus.cause_o, 32'h0000_0028);
      readReg("cmp_read", 5'd11, TIMER_ON ? 32'h1234 : 32'd0);
      applyStimulus(5'd13, 32'h0000_0100);
      checkOutput("sw_cause", bus.cause_o, 32'h0000_0128);
      checkOutput("sw_pend", {31'd0, bus.int_pending}, 32'd1);

      // MTC0 with commit_valid low is ignored
      bus.mtc0_we = 1'b1;  bus.addr = 5'd14;  bus.wdata = 32'hDEAD_BEEF;
      tick();
      bus.mtc0_we = 1'b0;
      checkOutput("nocommit_epc", bus.epc_o, 32'h400);

      // Interrupt outranks a same-cycle MTC0
      bus.commit_valid = 1'b1;  bus.commit_pc = 32'h500;
      bus.mtc0_we = 1'b1;       bus.addr = 5'd12;  bus.wdata = 32'd0;
      tick();
      bus.commit_valid = 1'b0;  bus.mtc0_we = 1'b0;
      checkOutput("swint_status", bus.status_o, 32'h0000_0103);
      checkOutput("swint_epc", bus.epc_o, 32'h500);
      checkOutput("swint_cause", bus.cause_o, 32'h0000_0100);
      checkOutput("swint_flush_pc", bus.flush_pc, VEC);

      // hw_int[0] samples into IP2
      bus.hw_int = 6'b000001;
      tick();
      checkOutput("hw0_cause", bus.cause_o, 32'h0000_0500);
      bus.hw_int = 6'b000000;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
